// File: rtl/cv32e40p_x_wb_arbiter.sv
// Arbitrates the shared register-file write port between EX-stage core results and
// buffered CORE-V-X coprocessor results. The core wins unless aging or a full FIFO forces a slot.
module cv32e40p_x_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4,
    parameter int ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                x_result_valid_i,
    output logic                x_result_ready_o,
    input  logic [ID_WIDTH-1:0] x_result_id_i,
    input  logic [4:0]          x_result_rd_i,
    input  logic                x_result_we_i,
    input  logic [31:0]         x_result_data_i,
    input  logic                core_we_i,
    input  logic [5:0]          core_waddr_i,
    input  logic [31:0]         core_wdata_i,
    output logic                core_wb_ready_o,
    output logic                rf_we_o,
    output logic [5:0]          rf_waddr_o,
    output logic [31:0]         rf_wdata_o,
    output logic                x_retire_valid_o,
    output logic [ID_WIDTH-1:0] x_retire_id_o,
    output logic                x_busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [4:0]          rd;
        logic                we;
        logic [31:0]         data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [CW-1:0]   wait_cnt;

    entry_t          head;
    logic            empty;
    logic            full;
    logic            head_null;
    logic            head_write;
    logic            grant_x;
    logic            pop;
    logic            push;

    // Handshake: a result transfers on a cycle where x_result_valid_i & x_result_ready_o are
    // both high; ready depends only on FIFO occupancy, never on valid.
    assign head       = mem[rd_ptr[AW-1:0]];
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head_null  = ~head.we || (head.rd == 5'd0);
    assign head_write = ~empty && ~head_null;

    // A full FIFO forces the slot even before aging expires so the producer cannot deadlock.
    assign grant_x = head_write && (~core_we_i || (wait_cnt == CNT_MAX) || full);
    assign pop     = ~empty && (head_null || grant_x);
    assign push    = x_result_valid_i && ~full;

    assign x_result_ready_o = ~full;
    assign x_busy_o         = ~empty;
    assign core_wb_ready_o  = ~(grant_x && core_we_i);
    assign x_retire_valid_o = pop;
    assign x_retire_id_o    = pop ? head.id : '0;
    assign rf_we_o          = grant_x ? 1'b1 : core_we_i;
    assign rf_waddr_o       = grant_x ? {1'b0, head.rd} : core_waddr_i;
    assign rf_wdata_o       = grant_x ? head.data : core_wdata_i;

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{id: x_result_id_i, rd: x_result_rd_i,
                                     we: x_result_we_i, data: x_result_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wait_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                wait_cnt <= '0;
            end else if (head_write && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + CNT_ONE;
            end
        end
    end

endmodule
